// File: rtl/audio_codec_rjm_slave_pkg.sv
// Shared types and default sizes for the right-justified audio codec slave.
package audio_codec_rjm_slave_pkg;

    localparam int WD_DEF          = 24;
    localparam int CNT_W_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

endpackage

// File: rtl/audio_codec_rjm_slave_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input, followed by one delay
// flop so rising/falling/any edges can be flagged for one clk_i cycle.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic                   w_q;

    // Synchroniser chain and edge-detect delay flop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(d_i);
            r_dly  <= w_q;
        end
    end

    assign w_q    = r_sync[SYNC_STAGES-1];
    assign q_o    = w_q;
    assign rise_o = w_q & ~r_dly;
    assign fall_o = ~w_q & r_dly;
    assign edge_o = w_q ^ r_dly;

endmodule

// File: rtl/audio_codec_rjm_slave.sv
// Right-justified audio interface slave: receives serial DAC words, measures
// the half-frame length from LRCK and transmits parallel ADC words aligned to it.
module audio_codec_rjm_slave
    import audio_codec_rjm_slave_pkg::*;
#(
    parameter int WD          = WD_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          codec_bclk_i,
    input  logic          codec_lrck_i,
    input  logic          dac_serial_data_i,
    input  logic [WD-1:0] adc_left_i,
    input  logic [WD-1:0] adc_right_i,
    output logic          adc_serial_data_o,
    output logic [WD-1:0] dac_left_o,
    output logic [WD-1:0] dac_right_o,
    output logic          dac_valid_o,
    output logic          dac_chan_o,
    output logic          frame_err_o,
    output logic          locked_o
);

    localparam logic [CNT_W:0] LEN_WD = (CNT_W+1)'(WD);

    // A half-frame shorter than one word starts transmission immediately.
    function automatic logic [CNT_W:0] start_index(input logic [CNT_W-1:0] len);
        logic [CNT_W:0] w_len;
        w_len = {1'b0, len};
        if (w_len < LEN_WD) begin
            start_index = '0;
        end else begin
            start_index = w_len - LEN_WD;
        end
    endfunction

    logic w_bclk_q, w_bclk_rise, w_bclk_fall, w_bclk_edge;
    logic w_lrck_q, w_lrck_rise, w_lrck_fall, w_lrck_edge;
    logic w_dac_bit, w_dac_rise, w_dac_fall, w_dac_edge;
    logic w_unused;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(codec_bclk_i),
        .q_o(w_bclk_q), .rise_o(w_bclk_rise), .fall_o(w_bclk_fall), .edge_o(w_bclk_edge)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(codec_lrck_i),
        .q_o(w_lrck_q), .rise_o(w_lrck_rise), .fall_o(w_lrck_fall), .edge_o(w_lrck_edge)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dac (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(dac_serial_data_i),
        .q_o(w_dac_bit), .rise_o(w_dac_rise), .fall_o(w_dac_fall), .edge_o(w_dac_edge)
    );

    assign w_unused = ^{w_bclk_q, w_bclk_edge, w_lrck_rise, w_lrck_fall,
                        w_dac_rise, w_dac_fall, w_dac_edge};

    state_e           r_state;
    logic [WD-1:0]    r_rx_sr;
    logic [WD-1:0]    r_tx_sr;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_half_len;
    logic [WD-1:0]    r_dac_left;
    logic [WD-1:0]    r_dac_right;
    logic             r_valid;
    logic             r_chan;
    logic             r_frame_err;
    logic             r_locked;
    logic             r_adc_out;
    logic [CNT_W:0]   w_start;

    assign w_start = start_index(r_half_len);

    // Lock FSM, receive/transmit shifters and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_bit_cnt   <= '0;
            r_half_len  <= '0;
            r_dac_left  <= '0;
            r_dac_right <= '0;
            r_valid     <= 1'b0;
            r_chan      <= 1'b0;
            r_frame_err <= 1'b0;
            r_locked    <= 1'b0;
            r_adc_out   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_lrck_edge) begin
                // w_lrck_q is the new level, so the finished half is its inverse.
                if (w_lrck_q) begin
                    r_dac_right <= r_rx_sr;
                end else begin
                    r_dac_left <= r_rx_sr;
                end
                r_chan     <= ~w_lrck_q;
                r_half_len <= r_bit_cnt;
                r_rx_sr    <= w_bclk_rise ? {{(WD-1){1'b0}}, w_dac_bit} : '0;
                r_bit_cnt  <= w_bclk_rise ? CNT_W'(1) : '0;
                if (w_bclk_fall) begin
                    r_adc_out <= 1'b0;
                end
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_MEASURE;
                    end
                    ST_MEASURE, ST_RUN: begin
                        r_state  <= ST_RUN;
                        r_locked <= 1'b1;
                        r_valid  <= 1'b1;
                        r_tx_sr  <= w_lrck_q ? adc_left_i : adc_right_i;
                        if ({1'b0, r_bit_cnt} < LEN_WD) begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end else begin
                if (w_bclk_rise) begin
                    r_rx_sr   <= {r_rx_sr[WD-2:0], w_dac_bit};
                    r_bit_cnt <= (&r_bit_cnt) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);
                end
                if (w_bclk_fall) begin
                    if (r_state == ST_RUN && {1'b0, r_bit_cnt} >= w_start) begin
                        r_adc_out <= r_tx_sr[WD-1];
                        r_tx_sr   <= r_tx_sr << 1;
                    end else begin
                        r_adc_out <= 1'b0;
                    end
                end
            end
        end
    end

    assign adc_serial_data_o = r_adc_out;
    assign dac_left_o        = r_dac_left;
    assign dac_right_o       = r_dac_right;
    assign dac_valid_o       = r_valid;
    assign dac_chan_o        = r_chan;
    assign frame_err_o       = r_frame_err;
    assign locked_o          = r_locked;

endmodule

// File: tb/tb_audio_codec_rjm_slave.sv
// Bench acting as interface master; DAC words are scoreboarded, ADC bits captured on BCLK rise.
module tb_audio_codec_rjm_slave;

    localparam int WD = 24;
    localparam int HB = 80;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bclk = 1'b1;
    logic          lrck = 1'b0;
    logic          dacd = 1'b0;
    logic [WD-1:0] adc_l = '0;
    logic [WD-1:0] adc_r = '0;
    logic          adc_serial_data_o;
    logic [WD-1:0] dac_left_o;
    logic [WD-1:0] dac_right_o;
    logic          dac_valid_o;
    logic          dac_chan_o;
    logic          frame_err_o;
    logic          locked_o;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_valid = 0;
    logic [WD:0]   sb_q[$];
    logic [WD:0]   mon_exp;
    logic [WD:0]   mon_obs;

    audio_codec_rjm_slave dut (
        .clk_i(clk), .rst_ni(rst_n), .codec_bclk_i(bclk), .codec_lrck_i(lrck),
        .dac_serial_data_i(dacd), .adc_left_i(adc_l), .adc_right_i(adc_r),
        .adc_serial_data_o(adc_serial_data_o), .dac_left_o(dac_left_o),
        .dac_right_o(dac_right_o), .dac_valid_o(dac_valid_o), .dac_chan_o(dac_chan_o),
        .frame_err_o(frame_err_o), .locked_o(locked_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dac_valid_o === 1'b1) begin
            n_valid++;
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid chan=%0b left=%h right=%h", dac_chan_o, dac_left_o, dac_right_o);
            end else begin
                mon_exp = sb_q.pop_front();
                mon_obs = {dac_chan_o, (mon_exp[WD] ? dac_left_o : dac_right_o)};
                if (mon_obs !== mon_exp) begin
                    n_err++;
                    $display("FAIL dac_word got {chan,word}=%h expected %h", mon_obs, mon_exp);
                end
            end
        end
    end

    task automatic send_half(input logic lvl, input int nbits, input logic [WD-1:0] word,
                             input bit push, output logic [63:0] cap);
        logic [WD-1:0] m;
        cap = '0;
        if (push) begin
            m = (nbits >= WD) ? word : (word & ((WD'(1) << nbits) - WD'(1)));
            sb_q.push_back({lvl, m});
        end
        for (int k = 0; k < nbits; k++) begin
            int idx;
            idx  = nbits - 1 - k;
            bclk = 1'b0;
            lrck = lvl;
            dacd = (idx < WD) ? word[idx] : 1'b0;
            #(HB);
            bclk = 1'b1;
            cap  = {cap[62:0], adc_serial_data_o};
            #(HB);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bclk  = 1'b1;
        lrck  = 1'b0;
        dacd  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        repeat (10) @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain pending=%0d expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [2*WD+4:0] obs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        obs = {dac_left_o, dac_right_o, dac_valid_o, dac_chan_o, frame_err_o, locked_o, adc_serial_data_o};
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %h expected 0", obs);
        end
    endtask

    task automatic test_lock_loopback();
        logic [63:0] cap;
        int v0;
        do_reset();
        v0 = n_valid;
        send_half(1'b0, 10, '0, 1'b0, cap);
        send_half(1'b1, 32, 24'hA5A5A5, 1'b1, cap);
        n_vec++;
        if (locked_o !== 1'b0 || n_valid != v0) begin
            n_err++;
            $display("FAIL lock_early locked=%0b valids=%0d expected 0/0", locked_o, n_valid - v0);
        end
        send_half(1'b0, 32, 24'h5A5A5A, 1'b1, cap);
        n_vec++;
        if (locked_o !== 1'b1) begin
            n_err++;
            $display("FAIL lock_second_edge locked=%0b expected 1", locked_o);
        end
        send_half(1'b1, 32, 24'hA5A5A5, 1'b1, cap);
        send_half(1'b0, 32, 24'h5A5A5A, 1'b1, cap);
        send_half(1'b1, 4, '0, 1'b0, cap);
        drain("loopback");
        n_vec++;
        if (n_valid - v0 != 4 || dac_left_o !== 24'hA5A5A5 || dac_right_o !== 24'h5A5A5A) begin
            n_err++;
            $display("FAIL loopback_final valids=%0d left=%h right=%h expected 4/a5a5a5/5a5a5a",
                     n_valid - v0, dac_left_o, dac_right_o);
        end
    endtask

    task automatic test_adc();
        logic [63:0] cap;
        adc_l = 24'h800001;
        adc_r = 24'h3C3C3C;
        do_reset();
        send_half(1'b0, 10, '0, 1'b0, cap);
        send_half(1'b1, 32, 24'h111111, 1'b1, cap);
        n_vec++;
        if (cap[31:0] !== 32'h0) begin
            n_err++;
            $display("FAIL adc_measure_zero got %h expected 0", cap[31:0]);
        end
        send_half(1'b0, 32, 24'h222222, 1'b1, cap);
        n_vec++;
        if (cap[31:0] !== {8'h00, 24'h3C3C3C}) begin
            n_err++;
            $display("FAIL adc_right got %h expected 003c3c3c", cap[31:0]);
        end
        send_half(1'b1, 32, 24'h333333, 1'b1, cap);
        n_vec++;
        if (cap[23:0] !== 24'h800001) begin
            n_err++;
            $display("FAIL adc_left got %h expected 800001", cap[23:0]);
        end
        n_vec++;
        if (cap[31:23] !== 9'b000000001) begin
            n_err++;
            $display("FAIL adc_lead_zeros got %b expected 000000001", cap[31:23]);
        end
        send_half(1'b0, 32, 24'h444444, 1'b1, cap);
        n_vec++;
        if (cap[31:0] !== {8'h00, 24'h3C3C3C}) begin
            n_err++;
            $display("FAIL adc_right2 got %h expected 003c3c3c", cap[31:0]);
        end
        send_half(1'b1, 4, '0, 1'b0, cap);
        drain("adc");
        n_vec++;
        if (frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL adc_no_frame_err got %0b expected 0", frame_err_o);
        end
    endtask

    task automatic test_short_frame();
        logic [63:0] cap;
        do_reset();
        send_half(1'b0, 5, '0, 1'b0, cap);
        send_half(1'b1, 16, 24'hABCD12, 1'b1, cap);
        n_vec++;
        if (frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL short_err_early got %0b expected 0", frame_err_o);
        end
        send_half(1'b0, 16, 24'h00BEEF, 1'b1, cap);
        n_vec++;
        if (frame_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL short_err_rise got %0b expected 1", frame_err_o);
        end
        send_half(1'b1, 16, 24'h7E1357, 1'b1, cap);
        send_half(1'b0, 4, '0, 1'b0, cap);
        drain("short");
        n_vec++;
        if (frame_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL short_err_sticky got %0b expected 1", frame_err_o);
        end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] cap;
        logic [2*WD+4:0] obs;
        int v0;
        do_reset();
        send_half(1'b0, 10, '0, 1'b0, cap);
        send_half(1'b1, 32, 24'h13579B, 1'b1, cap);
        send_half(1'b0, 32, 24'h2468AC, 1'b1, cap);
        send_half(1'b1, 10, 24'hFFFFFF, 1'b0, cap);
        @(negedge clk);
        rst_n = 1'b0;
        bclk  = 1'b1;
        lrck  = 1'b0;
        dacd  = 1'b0;
        repeat (3) @(negedge clk);
        obs = {dac_left_o, dac_right_o, dac_valid_o, dac_chan_o, frame_err_o, locked_o, adc_serial_data_o};
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL midframe_reset_outputs got %h expected 0", obs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        v0 = n_valid;
        send_half(1'b0, 10, '0, 1'b0, cap);
        send_half(1'b1, 32, 24'hC0FFEE, 1'b1, cap);
        n_vec++;
        if (n_valid != v0 || locked_o !== 1'b0) begin
            n_err++;
            $display("FAIL relock_early valids=%0d locked=%0b expected 0/0", n_valid - v0, locked_o);
        end
        send_half(1'b0, 32, 24'h0DD0BA, 1'b1, cap);
        send_half(1'b1, 4, '0, 1'b0, cap);
        drain("midframe");
    endtask

    task automatic test_coincident();
        logic [63:0] cap;
        do_reset();
        send_half(1'b0, 10, '0, 1'b0, cap);
        send_half(1'b1, 32, 24'h10A0B0, 1'b1, cap);
        send_half(1'b0, 32, 24'h20C0D0, 1'b1, cap);
        send_half(1'b1, 32, 24'h30E0F0, 1'b1, cap);
        bclk = 1'b0;
        dacd = 1'b1;
        #(HB);
        bclk = 1'b1;
        lrck = 1'b0;
        #(40);
        n_vec++;
        if (dut.r_bit_cnt !== 8'd1 || dut.r_rx_sr !== 24'h000001) begin
            n_err++;
            $display("FAIL coincident cnt=%0d rx=%h expected 1/000001", dut.r_bit_cnt, dut.r_rx_sr);
        end
        #(40);
        drain("coincident");
    endtask

    initial begin
        test_reset();
        test_lock_loopback();
        test_adc();
        test_short_frame();
        test_reset_midframe();
        test_coincident();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
